// File: rtl/pulse_seq_pkg.sv
// Shared types and constants for the pulse program sequencer.
package pulse_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_e;

  // Symbol bit roles: bit1 = output level, bit0 = duration select (0 = a, 1 = b).
  localparam int unsigned SYM_LEVEL_BIT = 1;
  localparam int unsigned SYM_SEL_BIT   = 0;

  localparam int unsigned SYMS_PER_WORD = 16;
  localparam int unsigned SYM_IDX_W     = $clog2(SYMS_PER_WORD);

endpackage

// File: rtl/pulse_symbol_decode.sv
// Extracts the current 2-bit symbol from a packed word and maps it to level and duration.
module pulse_symbol_decode
  import pulse_seq_pkg::*;
#(
  parameter int unsigned DUR_W = 8
) (
  input  logic [31:0]          i_mem_data,
  input  logic [SYM_IDX_W-1:0] i_sym_idx,
  input  logic [DUR_W-1:0]     i_dur_lo_a,
  input  logic [DUR_W-1:0]     i_dur_lo_b,
  input  logic [DUR_W-1:0]     i_dur_hi_a,
  input  logic [DUR_W-1:0]     i_dur_hi_b,
  output logic                 o_level,
  output logic [DUR_W-1:0]     o_dur
);

  logic [1:0] w_sym;

  assign w_sym = i_mem_data[{i_sym_idx, 1'b0} +: 2];

  // Select the duration entry by level and duration-select bit.
  always_comb begin
    o_level = w_sym[SYM_LEVEL_BIT];
    o_dur   = i_dur_lo_a;
    unique case ({w_sym[SYM_LEVEL_BIT], w_sym[SYM_SEL_BIT]})
      2'b00:   o_dur = i_dur_lo_a;
      2'b01:   o_dur = i_dur_lo_b;
      2'b10:   o_dur = i_dur_hi_a;
      default: o_dur = i_dur_hi_b;
    endcase
  end

endmodule

// File: rtl/pulse_program_sequencer.sv
// Steps a program counter through packed pulse symbols, holding each level for a tick count.
module pulse_program_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 4,
  parameter int unsigned PC_W      = 6,
  parameter int unsigned DUR_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_loop_en,
  input  logic [PC_W-1:0]  i_prog_start,
  input  logic [PC_W-1:0]  i_prog_end,
  input  logic             i_tick,
  input  logic [DUR_W-1:0] i_dur_lo_a,
  input  logic [DUR_W-1:0] i_dur_lo_b,
  input  logic [DUR_W-1:0] i_dur_hi_a,
  input  logic [DUR_W-1:0] i_dur_hi_b,
  output logic [PC_W-5:0]  o_mem_addr,
  input  logic [31:0]      i_mem_data,
  output logic             o_pulse_out,
  output logic             o_busy,
  output logic [PC_W-1:0]  o_pc,
  output logic             o_done_pulse,
  output logic             o_loop_pulse
);

  localparam int unsigned NumSyms = MEM_WORDS * SYMS_PER_WORD;

  state_e           r_state;
  logic [PC_W-1:0]  r_pc;
  logic [DUR_W-1:0] r_cnt;
  logic             r_pulse;
  logic             r_start_q;
  logic             r_done;
  logic             r_loop;

  logic             w_level;
  logic [DUR_W-1:0] w_dur;
  logic [PC_W-1:0]  w_pc_inc;

  u_decode_wrapper_unused_guard: assert property (@(posedge clk) 1'b1);

  pulse_symbol_decode #(
    .DUR_W (DUR_W)
  ) u_decode (
    .i_mem_data (i_mem_data),
    .i_sym_idx  (r_pc[SYM_IDX_W-1:0]),
    .i_dur_lo_a (i_dur_lo_a),
    .i_dur_lo_b (i_dur_lo_b),
    .i_dur_hi_a (i_dur_hi_a),
    .i_dur_hi_b (i_dur_hi_b),
    .o_level    (w_level),
    .o_dur      (w_dur)
  );

  // Next symbol index; wraps from the last table entry back to 0.
  always_comb begin
    w_pc_inc = r_pc + 1'b1;
    if (r_pc == PC_W'(NumSyms - 1)) w_pc_inc = '0;
  end

  // Sequencer FSM with registered level, strobes and program counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_cnt     <= '0;
      r_pulse   <= 1'b0;
      r_done    <= 1'b0;
      r_loop    <= 1'b0;
      // Track start through reset so an edge that arrived during reset is absorbed.
      r_start_q <= i_start;
    end else begin
      r_start_q <= i_start;
      r_done    <= 1'b0;
      r_loop    <= 1'b0;
      if (!i_start) begin
        // Abort wins over any tick, including a final one.
        r_state <= IDLE;
        r_pulse <= 1'b0;
        r_pc    <= '0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (!r_start_q) begin
              r_state <= LOAD;
              r_pc    <= i_prog_start;
            end
          end
          LOAD: begin
            r_pulse <= w_level;
            r_cnt   <= w_dur;
            r_state <= RUN;
          end
          RUN: begin
            if (i_tick) begin
              if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
              end else if (r_pc != i_prog_end) begin
                r_pc    <= w_pc_inc;
                r_state <= LOAD;
              end else if (i_loop_en) begin
                r_pc    <= i_prog_start;
                r_loop  <= 1'b1;
                r_state <= LOAD;
              end else begin
                r_pulse <= 1'b0;
                r_done  <= 1'b1;
                r_state <= IDLE;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_mem_addr   = r_pc[PC_W-1:SYM_IDX_W];
  assign o_pulse_out  = r_pulse;
  assign o_busy       = (r_state != IDLE);
  assign o_pc         = r_pc;
  assign o_done_pulse = r_done;
  assign o_loop_pulse = r_loop;

endmodule

// File: tb/tb_pulse_program_sequencer.sv
// Directed scoreboard bench for pulse_program_sequencer.
module tb_pulse_program_sequencer;

  localparam int PC_W  = 6;
  localparam int DUR_W = 8;

  typedef struct {
    logic pulse;
    logic busy;
    logic done;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             loop_en = 1'b0;
  logic [PC_W-1:0]  prog_start = '0;
  logic [PC_W-1:0]  prog_end = '0;
  logic             tick;
  logic [DUR_W-1:0] dur_lo_a = 8'd1;
  logic [DUR_W-1:0] dur_lo_b = 8'd2;
  logic [DUR_W-1:0] dur_hi_a = 8'd0;
  logic [DUR_W-1:0] dur_hi_b = 8'd3;
  logic [PC_W-5:0]  mem_addr;
  logic [31:0]      mem_data;
  logic             pulse_out;
  logic             busy;
  logic [PC_W-1:0]  pc;
  logic             done_pulse;
  logic             loop_pulse;

  logic [31:0] mem [4];
  int          tick_period = 1;
  int          tick_ctr = 0;
  int          total = 0;
  int          bad = 0;

  assign mem_data = mem[mem_addr];
  assign tick     = (tick_ctr == 0);

  always #5 clk = ~clk;

  always @(posedge clk) tick_ctr <= (tick_ctr >= tick_period - 1) ? 0 : tick_ctr + 1;

  pulse_program_sequencer #(
    .MEM_WORDS (4),
    .PC_W      (PC_W),
    .DUR_W     (DUR_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (start),
    .i_loop_en    (loop_en),
    .i_prog_start (prog_start),
    .i_prog_end   (prog_end),
    .i_tick       (tick),
    .i_dur_lo_a   (dur_lo_a),
    .i_dur_lo_b   (dur_lo_b),
    .i_dur_hi_a   (dur_hi_a),
    .i_dur_hi_b   (dur_hi_b),
    .o_mem_addr   (mem_addr),
    .i_mem_data   (mem_data),
    .o_pulse_out  (pulse_out),
    .o_busy       (busy),
    .o_pc         (pc),
    .o_done_pulse (done_pulse),
    .o_loop_pulse (loop_pulse)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int sym_dur(input logic [1:0] sym);
    case (sym)
      2'b00:   return int'(dur_lo_a);
      2'b01:   return int'(dur_lo_b);
      2'b10:   return int'(dur_hi_a);
      default: return int'(dur_hi_b);
    endcase
  endfunction

  initial begin
    exp_t        sq[$];
    logic [5:0]  pq[$];
    logic [1:0]  aq[$];
    exp_t        e;
    logic [31:0] word;
    logic [1:0]  sym;
    logic [5:0]  last_pc;
    logic [5:0]  epc;
    logic [1:0]  eaddr;
    int          loops;
    int          dones;

    mem[0] = 32'h0000_00E4;
    mem[1] = 32'h0;
    mem[2] = 32'h0;
    mem[3] = 32'hC000_0000;

    // Reset state
    step(2);
    check("rst_pulse", {31'b0, pulse_out}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_pc", {26'b0, pc}, 0);
    check("rst_done", {31'b0, done_pulse}, 0);
    check("rst_loop", {31'b0, loop_pulse}, 0);
    rst_n = 1'b1;
    step(1);

    // One-shot program 0..3, tick every cycle
    prog_start = 6'd0;
    prog_end   = 6'd3;
    loop_en    = 1'b0;
    word       = mem[0];
    sq.push_back('{pulse: 1'b0, busy: 1'b1, done: 1'b0});
    for (int k = 0; k < 4; k++) begin
      sym = word[2*k +: 2];
      for (int j = 0; j < sym_dur(sym) + ((k == 3) ? 1 : 2); j++)
        sq.push_back('{pulse: sym[1], busy: 1'b1, done: 1'b0});
    end
    sq.push_back('{pulse: 1'b0, busy: 1'b0, done: 1'b1});
    sq.push_back('{pulse: 1'b0, busy: 1'b0, done: 1'b0});
    start = 1'b1;
    while (sq.size() > 0) begin
      step(1);
      e = sq.pop_front();
      check("os_pulse", {31'b0, pulse_out}, {31'b0, e.pulse});
      check("os_busy", {31'b0, busy}, {31'b0, e.busy});
      check("os_done", {31'b0, done_pulse}, {31'b0, e.done});
    end

    // Restart gating: start held high does not relaunch
    step(4);
    check("gate_idle", {31'b0, busy}, 0);
    start = 1'b0;
    step(1);
    prog_start = 6'd2;
    prog_end   = 6'd2;
    start      = 1'b1;
    step(1);
    check("relaunch_busy", {31'b0, busy}, 1);
    check("relaunch_pc", {26'b0, pc}, 2);
    step(1);
    check("relaunch_pulse", {31'b0, pulse_out}, 1);
    step(1);
    check("relaunch_done", {31'b0, done_pulse}, 1);
    check("relaunch_idle", {31'b0, busy}, 0);

    // Abort coincident with final tick of the last symbol
    start = 1'b0;
    step(1);
    prog_start = 6'd3;
    prog_end   = 6'd3;
    start      = 1'b1;
    step(2);
    check("abort_pre_pulse", {31'b0, pulse_out}, 1);
    step(3);
    start = 1'b0;
    step(1);
    check("abort_busy", {31'b0, busy}, 0);
    check("abort_pulse", {31'b0, pulse_out}, 0);
    check("abort_pc", {26'b0, pc}, 0);
    check("abort_done", {31'b0, done_pulse}, 0);
    step(1);
    check("abort_done2", {31'b0, done_pulse}, 0);

    // Looped playback, tick every 4th cycle
    prog_start  = 6'd0;
    prog_end    = 6'd3;
    loop_en     = 1'b1;
    tick_period = 4;
    for (int r = 0; r < 2; r++) begin
      pq.push_back(6'd1);
      pq.push_back(6'd2);
      pq.push_back(6'd3);
      pq.push_back(6'd0);
    end
    last_pc = pc;
    loops   = 0;
    dones   = 0;
    start   = 1'b1;
    for (int cyc = 0; cyc < 400 && pq.size() > 0; cyc++) begin
      step(1);
      if (done_pulse) dones++;
      if (loop_pulse) loops++;
      if (pc !== last_pc) begin
        epc = pq.pop_front();
        check("loop_pc", {26'b0, pc}, {26'b0, epc});
        check("loop_strobe", {31'b0, loop_pulse}, {31'b0, (epc == 6'd0)});
        last_pc = pc;
      end
    end
    check("loop_seq_left", pq.size(), 0);
    check("loop_count", loops, 2);
    check("loop_no_done", dones, 0);
    start = 1'b0;
    step(1);

    // Wrap-around program 62..1
    loop_en     = 1'b0;
    tick_period = 1;
    prog_start  = 6'd62;
    prog_end    = 6'd1;
    pq.push_back(6'd62); aq.push_back(2'd3);
    pq.push_back(6'd63); aq.push_back(2'd3);
    pq.push_back(6'd0);  aq.push_back(2'd0);
    pq.push_back(6'd1);  aq.push_back(2'd0);
    last_pc = pc;
    dones   = 0;
    start   = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      step(1);
      if (done_pulse) dones++;
      if (pc !== last_pc && pq.size() > 0) begin
        epc   = pq.pop_front();
        eaddr = aq.pop_front();
        check("wrap_pc", {26'b0, pc}, {26'b0, epc});
        check("wrap_addr", {30'b0, mem_addr}, {30'b0, eaddr});
        last_pc = pc;
      end
    end
    check("wrap_seq_left", pq.size(), 0);
    check("wrap_done", dones, 1);
    check("wrap_idle", {31'b0, busy}, 0);

    // Reset mid-RUN with start held high
    start = 1'b0;
    step(1);
    prog_start = 6'd2;
    prog_end   = 6'd3;
    start      = 1'b1;
    step(3);
    check("rr_pre_pulse", {31'b0, pulse_out}, 1);
    rst_n = 1'b0;
    step(1);
    check("rr_pulse", {31'b0, pulse_out}, 0);
    check("rr_busy", {31'b0, busy}, 0);
    check("rr_pc", {26'b0, pc}, 0);
    check("rr_done", {31'b0, done_pulse}, 0);
    check("rr_loop", {31'b0, loop_pulse}, 0);
    rst_n = 1'b1;
    step(3);
    check("rr_no_launch", {31'b0, busy}, 0);
    check("rr_pc_after", {26'b0, pc}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
